// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman guess tracker.
package hangman_pkg;

  localparam int unsigned LETTER_W   = 5;
  localparam int unsigned ALPHA_SIZE = 26;
  localparam int unsigned CODE_MIN   = 0;
  localparam int unsigned CODE_MAX   = 25;
  localparam int unsigned WRONG_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WON  = 2'd2,
    ST_LOST = 2'd3
  } state_e;

endpackage

// File: rtl/guess_tracker_if.sv
// Guess handshake: the player drives letter/valid, the tracker answers with ready.
interface guess_if;
  import hangman_pkg::*;

  logic [LETTER_W-1:0] guess_letter;
  logic                guess_valid;
  logic                guess_ready;

  modport master (output guess_letter, output guess_valid, input guess_ready);
  modport slave  (input guess_letter, input guess_valid, output guess_ready);
endinterface

// File: rtl/guess_tracker_letter_decode.sv
// Letter code to one-hot alphabet bit; codes past Z decode to nothing.
module letter_decode
  import hangman_pkg::*;
(
  input  logic [LETTER_W-1:0]   i_code,
  output logic [ALPHA_SIZE-1:0] o_onehot_c,
  output logic                  o_valid_c
);

  // Range check and one-hot expansion
  always_comb begin
    o_valid_c  = (i_code <= LETTER_W'(CODE_MAX));
    o_onehot_c = '0;
    if (o_valid_c) begin
      o_onehot_c = ALPHA_SIZE'(1) << i_code;
    end
  end

endmodule

// File: rtl/guess_tracker.sv
// Tracks guessed letters, wrong guesses and win/loss for one hangman level.
module guess_tracker
  import hangman_pkg::*;
#(
  parameter int unsigned NUM_LETTERS = 6,
  parameter int unsigned MAX_WRONG   = 6
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start_level,
  input  logic [LETTER_W*NUM_LETTERS-1:0] word,
  input  logic [ALPHA_SIZE-1:0]           mask,
  guess_if.slave                          guess,
  output logic [ALPHA_SIZE-1:0]           guessed,
  output logic [NUM_LETTERS-1:0]          revealed,
  output logic [WRONG_W-1:0]              wrong_count,
  output logic                            repeat_guess,
  output logic                            won_level,
  output logic                            lost_game
);

  localparam int unsigned WORD_W = LETTER_W * NUM_LETTERS;

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [WORD_W-1:0]       r_word;
  logic [ALPHA_SIZE-1:0]   r_mask;
  logic [ALPHA_SIZE-1:0]   r_guessed;
  logic [WRONG_W-1:0]      r_wrong;
  logic                    r_repeat;
  logic                    r_ready;
  logic                    r_won;
  logic                    r_lost;
  logic                    w_ready_nxt;
  logic                    w_won_nxt;
  logic                    w_lost_nxt;
  logic [ALPHA_SIZE-1:0]   w_onehot;
  logic                    w_code_valid;
  logic                    w_accept;
  logic                    w_already;
  logic                    w_hit;
  logic                    w_all_found;
  logic                    w_wrong_max;
  logic [LETTER_W-1:0]     w_letter;
  logic [NUM_LETTERS-1:0]  w_revealed;

  letter_decode u_dec (
    .i_code     (guess.guess_letter),
    .o_onehot_c (w_onehot),
    .o_valid_c  (w_code_valid)
  );

  // start_level takes priority over a guess offered in the same cycle
  assign w_accept    = guess.guess_valid & r_ready & ~start_level;
  assign w_already   = |(r_guessed & w_onehot);
  assign w_hit       = |(r_mask & w_onehot);
  assign w_all_found = ((r_mask & ~r_guessed) == '0);
  assign w_wrong_max = (r_wrong == WRONG_W'(MAX_WRONG));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; WON/LOST hold until a new level starts
  always_comb begin
    w_state_nxt = r_state;
    if (start_level) begin
      w_state_nxt = ST_PLAY;
    end else begin
      case (r_state)
        ST_PLAY: begin
          if (w_all_found)      w_state_nxt = ST_WON;
          else if (w_wrong_max) w_state_nxt = ST_LOST;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Output decode from next state so the registered flags track the state register
  always_comb begin
    w_ready_nxt = 1'b0;
    w_won_nxt   = 1'b0;
    w_lost_nxt  = 1'b0;
    case (w_state_nxt)
      ST_PLAY: w_ready_nxt = 1'b1;
      ST_WON:  w_won_nxt   = 1'b1;
      ST_LOST: w_lost_nxt  = 1'b1;
      default: ;
    endcase
  end

  // Status flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_won   <= 1'b0;
      r_lost  <= 1'b0;
    end else begin
      r_ready <= w_ready_nxt;
      r_won   <= w_won_nxt;
      r_lost  <= w_lost_nxt;
    end
  end

  // Level latch and guess bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word    <= '0;
      r_mask    <= '0;
      r_guessed <= '0;
      r_wrong   <= '0;
      r_repeat  <= 1'b0;
    end else begin
      r_repeat <= 1'b0;
      if (start_level) begin
        r_word    <= word;
        r_mask    <= mask;
        r_guessed <= '0;
        r_wrong   <= '0;
      end else if (w_accept && w_code_valid) begin
        if (w_already) begin
          r_repeat <= 1'b1;
        end else begin
          r_guessed <= r_guessed | w_onehot;
          if (!w_hit && !w_wrong_max) r_wrong <= r_wrong + WRONG_W'(1);
        end
      end
    end
  end

  // Reveal each word position whose letter has been guessed (leftmost letter is MSB)
  always_comb begin
    w_revealed = '0;
    w_letter   = '0;
    for (int k = 0; k < int'(NUM_LETTERS); k++) begin
      w_letter = r_word[WORD_W-1-LETTER_W*k -: LETTER_W];
      w_revealed[NUM_LETTERS-1-k] = (w_letter <= LETTER_W'(CODE_MAX)) && r_guessed[w_letter];
    end
  end

  assign guess.guess_ready = r_ready;
  assign guessed           = r_guessed;
  assign revealed          = w_revealed;
  assign wrong_count       = r_wrong;
  assign repeat_guess      = r_repeat;
  assign won_level         = r_won;
  assign lost_game         = r_lost;

endmodule

// File: tb/tb_guess_tracker.sv
// Directed bench for guess_tracker using the BANANA level.
module tb_guess_tracker;
  import hangman_pkg::*;

  logic        clk;
  logic        reset;
  logic        start_level;
  logic [29:0] word;
  logic [25:0] mask;
  logic [25:0] guessed;
  logic [5:0]  revealed;
  logic [2:0]  wrong_count;
  logic        repeat_guess;
  logic        won_level;
  logic        lost_game;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [29:0] BANANA   = {5'd1, 5'd0, 5'd13, 5'd0, 5'd13, 5'd0};
  localparam logic [25:0] BAN_MASK = 26'h0002003;

  guess_if gif ();

  guess_tracker #(.NUM_LETTERS(6), .MAX_WRONG(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_level  (start_level),
    .word         (word),
    .mask         (mask),
    .guess        (gif),
    .guessed      (guessed),
    .revealed     (revealed),
    .wrong_count  (wrong_count),
    .repeat_guess (repeat_guess),
    .won_level    (won_level),
    .lost_game    (lost_game)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset            = 1'b1;
    start_level      = 1'b0;
    word             = BANANA;
    mask             = BAN_MASK;
    gif.guess_letter = 5'd0;
    gif.guess_valid  = 1'b0;
    #2;
    chk("rst_guessed", 32'(guessed), 32'h0);
    chk("rst_wrong", 32'(wrong_count), 32'h0);
    chk("rst_ready", 32'(gif.guess_ready), 32'h0);
    chk("rst_won_lost", 32'({won_level, lost_game, repeat_guess}), 32'h0);
    chk("rst_revealed", 32'(revealed), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_ready", 32'(gif.guess_ready), 32'h0);

    // Level 1: win with A, N, B
    start_level = 1'b1;
    tick();
    start_level = 1'b0;
    chk("start_ready", 32'(gif.guess_ready), 32'h1);
    chk("start_revealed", 32'(revealed), 32'h0);
    gif.guess_valid = 1'b1; gif.guess_letter = 5'd0;
    tick();
    gif.guess_valid = 1'b0;
    chk("A_revealed", 32'(revealed), 32'b010101);
    chk("A_wrong", 32'(wrong_count), 32'h0);
    chk("A_guessed", 32'(guessed), 32'h1);
    gif.guess_valid = 1'b1; gif.guess_letter = 5'd13;
    tick();
    gif.guess_valid = 1'b0;
    chk("N_revealed", 32'(revealed), 32'b011111);
    gif.guess_valid = 1'b1; gif.guess_letter = 5'd1;
    tick();
    gif.guess_valid = 1'b0;
    chk("B_revealed", 32'(revealed), 32'b111111);
    chk("B_won_n1", 32'(won_level), 32'h0);
    tick();
    chk("B_won_n2", 32'(won_level), 32'h1);
    chk("won_ready", 32'(gif.guess_ready), 32'h0);
    chk("won_lost", 32'(lost_game), 32'h0);
    tick();
    chk("won_hold", 32'(won_level), 32'h1);

    // Level 2: repeat and out-of-range guesses
    start_level = 1'b1;
    tick();
    start_level = 1'b0;
    chk("restart_guessed", 32'(guessed), 32'h0);
    chk("restart_won", 32'(won_level), 32'h0);
    gif.guess_valid = 1'b1; gif.guess_letter = 5'd0;
    tick();
    chk("rep1_pulse", 32'(repeat_guess), 32'h0);
    tick();
    gif.guess_valid = 1'b0;
    chk("rep2_pulse", 32'(repeat_guess), 32'h1);
    chk("rep2_wrong", 32'(wrong_count), 32'h0);
    chk("rep2_guessed", 32'(guessed), 32'h1);
    tick();
    chk("rep_pulse_end", 32'(repeat_guess), 32'h0);
    gif.guess_valid = 1'b1; gif.guess_letter = 5'd30;
    tick();
    gif.guess_valid = 1'b0;
    chk("c30_guessed", 32'(guessed), 32'h1);
    chk("c30_wrong_rep", 32'({wrong_count, repeat_guess}), 32'h0);

    // Lose with Z..U back to back
    for (int i = 0; i < 6; i++) begin
      gif.guess_valid  = 1'b1;
      gif.guess_letter = 5'(25 - i);
      tick();
      chk($sformatf("wrong_%0d", i + 1), 32'(wrong_count), 32'(i + 1));
    end
    gif.guess_letter = 5'd24;
    chk("lost_n1", 32'(lost_game), 32'h0);
    tick();
    chk("lost_n2", 32'(lost_game), 32'h1);
    chk("lost_ready", 32'(gif.guess_ready), 32'h0);
    chk("lost_won", 32'(won_level), 32'h0);
    gif.guess_letter = 5'd2;
    tick();
    gif.guess_valid = 1'b0;
    chk("lost_wrong_sat", 32'(wrong_count), 32'h6);
    chk("lost_guessed_frozen", 32'(guessed), 32'h03F00001);

    // Level 3: live word/mask changes after latch are ignored
    start_level = 1'b1;
    tick();
    start_level = 1'b0;
    word = {6{5'd2}};
    mask = 26'h0;
    gif.guess_valid = 1'b1; gif.guess_letter = 5'd0;
    tick();
    gif.guess_valid = 1'b0;
    chk("live_revealed", 32'(revealed), 32'b010101);
    chk("live_won", 32'(won_level), 32'h0);
    gif.guess_valid = 1'b1; gif.guess_letter = 5'd2;
    tick();
    gif.guess_valid = 1'b0;
    chk("live_wrong", 32'(wrong_count), 32'h1);

    // start_level beats a coincident guess
    word = BANANA;
    mask = BAN_MASK;
    start_level = 1'b1;
    gif.guess_valid = 1'b1; gif.guess_letter = 5'd13;
    tick();
    start_level = 1'b0;
    gif.guess_valid = 1'b0;
    chk("coinc_guessed", 32'(guessed), 32'h0);
    chk("coinc_wrong", 32'(wrong_count), 32'h0);
    gif.guess_valid = 1'b1; gif.guess_letter = 5'd13;
    tick();
    gif.guess_valid = 1'b0;
    chk("pre_rst_revealed", 32'(revealed), 32'b001010);

    // Asynchronous reset mid-level
    #2;
    reset = 1'b1;
    #1;
    chk("arst_guessed", 32'(guessed), 32'h0);
    chk("arst_revealed", 32'(revealed), 32'h0);
    chk("arst_ready", 32'(gif.guess_ready), 32'h0);
    chk("arst_flags", 32'({won_level, lost_game, repeat_guess, wrong_count}), 32'h0);
    tick();
    reset = 1'b0;
    gif.guess_valid = 1'b1; gif.guess_letter = 5'd0;
    tick();
    gif.guess_valid = 1'b0;
    chk("post_rst_ignored", 32'(guessed), 32'h0);
    chk("post_rst_ready", 32'(gif.guess_ready), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
